range_coalesce_16: RTL and testbench

//  Downstream of the 16-wide bitonic sorter. Takes one sorted block of 16 inclusive ID ranges (tuple_pair_t).

---
 rtl/range_coalesce_16_pkg.sv | 29 ++
 rtl/range_merge_step.sv | 22 ++
 rtl/range_coalesce_16.sv | 166 ++++++++++++++++
 tb/tb_range_coalesce_16.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_coalesce_16_pkg.sv
// rtl/range_coalesce_16_pkg.sv - shared types, widths and helpers for the range coalescer
package range_coalesce_16_pkg;

  localparam int ID_W              = 64;
  localparam int SUM_W             = ID_W + 5;
  localparam int NUM_PAIRS         = 16;
  localparam int PAIR_W            = 2 * ID_W;
  localparam int ARR_16_FLAT_WIDTH = NUM_PAIRS * PAIR_W;
  localparam int IDX_W             = 4;

  localparam logic [ID_W-1:0]  ID_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  // Inclusive range; lo occupies the upper half of the packed word.
  typedef struct packed {
    logic [ID_W-1:0] lo;
    logic [ID_W-1:0] hi;
  } tuple_pair_t;

  function automatic int index_flat(input int i);
    return i * PAIR_W;
  endfunction

  // One extra bit so [0,MAX] yields 2^ID_W instead of wrapping to zero.
  function automatic logic [ID_W:0] range_len(input tuple_pair_t r);
    return {1'b0, r.hi} - {1'b0, r.lo} + {{ID_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/range_merge_step.sv
// rtl/range_merge_step.sv - combinational overlap/adjacency test of the next element against the open range
module range_merge_step
  import range_coalesce_16_pkg::*;
(
  input  tuple_pair_t     i_cur,
  input  tuple_pair_t     i_e,
  output logic            o_merge,
  output logic [ID_W-1:0] o_merged_hi,
  output logic [ID_W:0]   o_len_cur
);

  logic w_overlap;
  logic w_adjacent;

  assign w_overlap   = (i_e.lo <= i_cur.hi);
  // cur.hi+1 would wrap to 0 at MAX, so adjacency is only meaningful below MAX.
  assign w_adjacent  = (i_cur.hi != ID_MAX) && (i_e.lo == i_cur.hi + 1'b1);
  assign o_merge     = w_overlap | w_adjacent;
  assign o_merged_hi = (i_e.hi > i_cur.hi) ? i_e.hi : i_cur.hi;
  assign o_len_cur   = range_len(i_cur);

endmodule

// File: rtl/range_coalesce_16.sv
// rtl/range_coalesce_16.sv - merges a sorted 16-range block into disjoint ranges plus covered-ID total
// Optional pad skipping (lo>hi elements ignored) is enabled by AOC5_COALESCE_PAD_SKIP_EN.
module range_coalesce_16
  import range_coalesce_16_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         valid_in,
  output logic                         in_ready,
  input  logic [ARR_16_FLAT_WIDTH-1:0] pairs_in_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAIR_W-1:0]            out_pair,
  output logic                         sum_valid,
  output logic [SUM_W-1:0]             sum_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_FLUSH, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  tuple_pair_t      r_blk [NUM_PAIRS];
  tuple_pair_t      r_cur;
  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_sum;

  tuple_pair_t      w_e;
  tuple_pair_t      w_first;
  logic             w_accept;
  logic             w_merge;
  logic [ID_W-1:0]  w_merged_hi;
  logic [ID_W:0]    w_len_cur;
  logic [SUM_W-1:0] w_acc_add;
  logic             w_out_valid;
  logic             w_load_cur;
  logic             w_merge_cur;
  logic             w_advance;
  logic             w_acc_en;
  logic             w_sum_en;

`ifdef AOC5_COALESCE_PAD_SKIP_EN
  logic r_cur_vld;
  logic w_e_pad;
  assign w_e_pad = (w_e.lo > w_e.hi);
`endif

  assign w_e       = r_blk[r_idx];
  assign w_first   = tuple_pair_t'(pairs_in_flat[index_flat(0) +: PAIR_W]);
  assign w_accept  = (r_state == ST_IDLE) && valid_in;
  assign w_acc_add = r_acc + {{(SUM_W-ID_W-1){1'b0}}, w_len_cur};

  range_merge_step u_step (
    .i_cur       (r_cur),
    .i_e         (w_e),
    .o_merge     (w_merge),
    .o_merged_hi (w_merged_hi),
    .o_len_cur   (w_len_cur)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_load_cur  = 1'b0;
    w_merge_cur = 1'b0;
    w_advance   = 1'b0;
    w_acc_en    = 1'b0;
    w_sum_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in) w_state_nxt = ST_WALK;
      end
      ST_WALK: begin
`ifdef AOC5_COALESCE_PAD_SKIP_EN
        if (w_e_pad) begin
          w_advance = 1'b1;
        end else if (!r_cur_vld) begin
          w_load_cur = 1'b1;
          w_advance  = 1'b1;
        end else
`endif
        if (w_merge) begin
          w_merge_cur = 1'b1;
          w_advance   = 1'b1;
        end else begin
          w_out_valid = 1'b1;
          if (out_ready) begin
            w_acc_en   = 1'b1;
            w_load_cur = 1'b1;
            w_advance  = 1'b1;
          end
        end
        if (w_advance && (r_idx == LAST_IDX)) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
`ifdef AOC5_COALESCE_PAD_SKIP_EN
        if (!r_cur_vld) begin
          w_sum_en    = 1'b1;
          w_state_nxt = ST_DONE;
        end else
`endif
        begin
          w_out_valid = 1'b1;
          if (out_ready) begin
            w_acc_en    = 1'b1;
            w_sum_en    = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
`ifdef AOC5_COALESCE_PAD_SKIP_EN
      r_cur_vld <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cur <= w_first;
        r_idx <= 4'd1;
        r_acc <= '0;
`ifdef AOC5_COALESCE_PAD_SKIP_EN
        r_cur_vld <= !(w_first.lo > w_first.hi);
`endif
      end else begin
        if (w_load_cur) begin
          r_cur <= w_e;
`ifdef AOC5_COALESCE_PAD_SKIP_EN
          r_cur_vld <= 1'b1;
`endif
        end else if (w_merge_cur) begin
          r_cur.hi <= w_merged_hi;
        end
        if (w_advance) r_idx <= r_idx + 1'b1;
        if (w_acc_en)  r_acc <= w_acc_add;
        if (w_sum_en)  r_sum <= w_acc_en ? w_acc_add : r_acc;
      end
    end
  end

  // Block storage carries no reset: it is only read after an accept reloads it.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_PAIRS; i++) begin
        r_blk[i] <= tuple_pair_t'(pairs_in_flat[index_flat(i) +: PAIR_W]);
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = w_out_valid;
  assign out_pair  = w_out_valid ? r_cur : '0;
  assign sum_valid = (r_state == ST_DONE);
  assign sum_out   = r_sum;

endmodule

// File: tb/tb_range_coalesce_16.sv
// tb/tb_range_coalesce_16.sv - randomized scoreboard bench for range_coalesce_16
module tb_range_coalesce_16;
  import range_coalesce_16_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         valid_in = 1'b0;
  logic                         in_ready;
  logic [ARR_16_FLAT_WIDTH-1:0] pairs_in_flat = '0;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic [PAIR_W-1:0]            out_pair;
  logic                         sum_valid;
  logic [SUM_W-1:0]             sum_out;

  always #5 clock = ~clock;

  range_coalesce_16 dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .valid_in      (valid_in),
    .in_ready      (in_ready),
    .pairs_in_flat (pairs_in_flat),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pair      (out_pair),
    .sum_valid     (sum_valid),
    .sum_out       (sum_out)
  );

  tuple_pair_t      exp_pairs [$];
  logic [SUM_W-1:0] exp_sums  [$];
  int               checks = 0;
  int               failures = 0;
  int               rdy_mode = 0;
  logic             man_ready = 1'b1;
  int               outs_seen = 0;
  int               sums_seen = 0;
  logic             busy = 1'b0;
  logic             stall_hold = 1'b0;
  logic [PAIR_W-1:0] stall_pair = '0;

  task automatic check(input string name, input logic [PAIR_W-1:0] act, input logic [PAIR_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [SUM_W-1:0] span(input logic [ID_W-1:0] lo, input logic [ID_W-1:0] hi);
    logic [SUM_W-1:0] a, b;
    a = hi;
    b = lo;
    return a - b + 1;
  endfunction

  // Reference: greedy union of sorted ranges; a gap exists only if next.lo > hi+1 (65-bit).
  task automatic model_block(input tuple_pair_t blk [NUM_PAIRS]);
    logic have;
    logic [ID_W-1:0] clo, chi;
    logic [SUM_W-1:0] s;
    tuple_pair_t e, p;
    have = 1'b0; s = '0; clo = '0; chi = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      e = blk[i];
`ifdef AOC5_COALESCE_PAD_SKIP_EN
      if (e.lo > e.hi) continue;
`endif
      if (!have) begin
        clo = e.lo; chi = e.hi; have = 1'b1;
      end else if ({1'b0, e.lo} <= {1'b0, chi} + 65'd1) begin
        if (e.hi > chi) chi = e.hi;
      end else begin
        p.lo = clo; p.hi = chi;
        exp_pairs.push_back(p);
        s = s + span(clo, chi);
        clo = e.lo; chi = e.hi;
      end
    end
    if (have) begin
      p.lo = clo; p.hi = chi;
      exp_pairs.push_back(p);
      s = s + span(clo, chi);
    end
    exp_sums.push_back(s);
  endtask

  task automatic send_block(input tuple_pair_t blk [NUM_PAIRS]);
    int t;
    t = 0;
    @(posedge clock); #1;
    while (!in_ready && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    for (int i = 0; i < NUM_PAIRS; i++) pairs_in_flat[index_flat(i) +: PAIR_W] = blk[i];
    valid_in = 1'b1;
    @(posedge clock); #1;
    valid_in = 1'b0;
  endtask

  task automatic run_block(input tuple_pair_t blk [NUM_PAIRS]);
    model_block(blk);
    send_block(blk);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_pairs.size() != 0 || exp_sums.size() != 0) && t < 5000) begin
      @(posedge clock); #1;
      t++;
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_pairs.size() != 0 || exp_sums.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp_pairs.size(), exp_sums.size());
      exp_pairs.delete();
      exp_sums.delete();
    end
  endtask

  task automatic rand_block(output tuple_pair_t blk [NUM_PAIRS]);
    logic [ID_W-1:0] base, len;
    tuple_pair_t tmp;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      base = ($urandom_range(0, 3) == 0) ? (ID_MAX - 64'd150) : 64'd0;
      blk[i].lo = base + 64'($urandom_range(0, 120));
      len = 64'($urandom_range(0, 12));
      blk[i].hi = ((ID_MAX - blk[i].lo) < len) ? ID_MAX : blk[i].lo + len;
    end
    for (int i = 1; i < NUM_PAIRS; i++) begin
      for (int j = i; j > 0 && blk[j-1].lo > blk[j].lo; j--) begin
        tmp = blk[j]; blk[j] = blk[j-1]; blk[j-1] = tmp;
      end
    end
  endtask

  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = man_ready;
    endcase
  end

  initial forever begin
    tuple_pair_t e;
    logic [SUM_W-1:0] s;
    @(negedge clock);
    if (!reset_n) begin
      busy = 1'b0;
      stall_hold = 1'b0;
    end else begin
      if (busy) check("in_ready_busy", in_ready, 0);
      if (stall_hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_pair", out_pair, stall_pair);
      end
      if (out_valid && out_ready) begin
        outs_seen++;
        if (exp_pairs.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_extra actual=%0h required=none", out_pair);
        end else begin
          e = exp_pairs.pop_front();
          check("out_pair", out_pair, e);
        end
      end
      stall_hold = out_valid && !out_ready;
      stall_pair = out_pair;
      if (sum_valid) begin
        sums_seen++;
        busy = 1'b0;
        if (exp_sums.size() == 0) begin
          checks++; failures++;
          $display("FAIL sum_extra actual=%0h required=none", sum_out);
        end else begin
          s = exp_sums.pop_front();
          check("sum_out", sum_out, s);
        end
      end
      if (valid_in && in_ready) busy = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tuple_pair_t blk [NUM_PAIRS];
    tuple_pair_t p;
    int s0, o0, n, t;

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_out_pair", out_pair, 0);
    check("rst_sum_out", sum_out, 0);
    reset_n = 1'b1;

    // all identical
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'd10; blk[i].hi = 64'd20; end
    s0 = sums_seen;
    run_block(blk);
    wait_drain();
    check("t1_sum_pulses", 32'(sums_seen - s0), 1);

    // all disjoint points
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'(2*i); blk[i].hi = 64'(2*i); end
    run_block(blk);
    wait_drain();

    // adjacent chain
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'(4*i); blk[i].hi = 64'(4*i+3); end
    run_block(blk);
    wait_drain();

    // disjoint points under 1010 backpressure
    rdy_mode = 1;
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'(2*i); blk[i].hi = 64'(2*i); end
    o0 = outs_seen;
    run_block(blk);
    wait_drain();
    check("t4_out_count", 32'(outs_seen - o0), 16);
    rdy_mode = 0;

    // full-width range, then MAX boundary pair
    blk[0].lo = 64'd0; blk[0].hi = ID_MAX;
    for (int i = 1; i < NUM_PAIRS; i++) begin blk[i].lo = 64'd5; blk[i].hi = 64'd5; end
    run_block(blk);
    wait_drain();
    for (int i = 0; i < 14; i++) begin blk[i].lo = 64'(3*i); blk[i].hi = 64'(3*i); end
    blk[14].lo = ID_MAX - 64'd1; blk[14].hi = ID_MAX;
    blk[15].lo = ID_MAX;         blk[15].hi = ID_MAX;
    run_block(blk);
    wait_drain();

    // reset after three accepted outputs
    rdy_mode = 3;
    man_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p.lo = 64'(2*i); p.hi = 64'(2*i);
      exp_pairs.push_back(p);
    end
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'(2*i); blk[i].hi = 64'(2*i); end
    send_block(blk);
    n = 0; t = 0;
    while (n < 3 && t < 200) begin
      @(negedge clock);
      if (out_valid && out_ready) n++;
      if (n == 3) man_ready = 1'b0;
      t++;
    end
    check("t6_three_outs", 32'(n), 3);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("t6_in_ready", in_ready, 1);
    check("t6_out_valid", out_valid, 0);
    reset_n = 1'b1;
    rdy_mode = 0;
    man_ready = 1'b1;
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = 64'(4*i); blk[i].hi = 64'(4*i+3); end
    run_block(blk);
    wait_drain();

`ifdef AOC5_COALESCE_PAD_SKIP_EN
    blk[0].lo = 64'd1; blk[0].hi = 64'd2;
    blk[1].lo = 64'd3; blk[1].hi = 64'd3;
    blk[2].lo = 64'd9; blk[2].hi = 64'd9;
    for (int i = 3; i < NUM_PAIRS; i++) begin blk[i].lo = ID_MAX; blk[i].hi = 64'd0; end
    run_block(blk);
    wait_drain();
    for (int i = 0; i < NUM_PAIRS; i++) begin blk[i].lo = ID_MAX; blk[i].hi = 64'd0; end
    run_block(blk);
    wait_drain();
`endif

    // randomized blocks under random backpressure
    rdy_mode = 2;
    for (int b = 0; b < 20; b++) begin
      rand_block(blk);
      run_block(blk);
    end
    wait_drain();
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
